// File: rtl/neuraedge_host_link_if.sv
// ----------------------------------------------------------------------------
// neuraedge_host_link_if
//   Bundles the handshake and data signals of the NPU host link endpoint.
//   master : the host link itself (drives cmd/pld ready, TX flits, RX ready,
//            and the decoded response stream).
//   slave  : the environment around it (host command source, NPU flit port,
//            response consumer).
// Signal groups:
//   cmd_*           command handshake and header fields from the host
//   pld_*           TX payload flits from the host
//   tx_*            flit stream towards the NPU ext_flit_in
//   rx_*            flit stream from the NPU ext_flit_out
//   rsp_hdr_valid,
//   rsp_tag/len/opcode  decoded response header (strobe + held fields)
//   rsp_data*       response payload stream
// ----------------------------------------------------------------------------
interface neuraedge_host_link_if #(
    parameter int unsigned FLIT_W = 64
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_dst_row;
    logic [3:0]        cmd_dst_col;
    logic [7:0]        cmd_len;
    logic [7:0]        cmd_tag;
    logic [5:0]        cmd_opcode;
    logic [31:0]       cmd_addr;

    logic              pld_valid;
    logic              pld_ready;
    logic [FLIT_W-1:0] pld_data;

    logic [FLIT_W-1:0] tx_flit;
    logic              tx_valid;
    logic              tx_ready;

    logic [FLIT_W-1:0] rx_flit;
    logic              rx_valid;
    logic              rx_ready;

    logic              rsp_hdr_valid;
    logic [7:0]        rsp_tag;
    logic [7:0]        rsp_len;
    logic [5:0]        rsp_opcode;
    logic [FLIT_W-1:0] rsp_data;
    logic              rsp_data_valid;
    logic              rsp_data_ready;

    modport master (
        input  cmd_valid, cmd_dst_row, cmd_dst_col, cmd_len, cmd_tag, cmd_opcode, cmd_addr,
        output cmd_ready,
        input  pld_valid, pld_data,
        output pld_ready,
        output tx_flit, tx_valid,
        input  tx_ready,
        input  rx_flit, rx_valid,
        output rx_ready,
        output rsp_hdr_valid, rsp_tag, rsp_len, rsp_opcode, rsp_data, rsp_data_valid,
        input  rsp_data_ready
    );

    modport slave (
        output cmd_valid, cmd_dst_row, cmd_dst_col, cmd_len, cmd_tag, cmd_opcode, cmd_addr,
        input  cmd_ready,
        output pld_valid, pld_data,
        input  pld_ready,
        input  tx_flit, tx_valid,
        output tx_ready,
        output rx_flit, rx_valid,
        input  rx_ready,
        input  rsp_hdr_valid, rsp_tag, rsp_len, rsp_opcode, rsp_data, rsp_data_valid,
        output rsp_data_ready
    );
endinterface

// File: rtl/neuraedge_host_link.sv
// ----------------------------------------------------------------------------
// neuraedge_host_link
//   Host-side endpoint of the NPU external flit port.
//   TX: packetizes host commands into a head flit plus cmd_len payload flits.
//   RX: depacketizes NPU responses into a header strobe and a payload stream.
//   Counts outstanding commands (one response packet expected per command).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   io_link         neuraedge_host_link_if.master (cmd, pld, tx, rx, rsp groups)
//   o_outstanding   commands whose response head has not yet arrived
//   o_err_len       sticky: command with cmd_len > MAX_LEN was dropped
//   o_err_timeout   sticky: watchdog expired (0 unless HOST_LINK_TIMEOUT_EN)
//   i_err_clr       clears both sticky errors; a same-cycle new error wins
//
// Build option:
//   HOST_LINK_TIMEOUT_EN  builds the response watchdog (limit TIMEOUT_CYC).
//
// Head flit: [63:60] row, [59:56] col, [55:48] len, [47:40] tag,
//            [37:32] opcode, [31:0] addr, all other bits 0.
// ----------------------------------------------------------------------------
module neuraedge_host_link #(
    parameter int unsigned FLIT_W      = 64,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned MAX_OUT     = 8,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned OUT_W      = $clog2(MAX_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuraedge_host_link_if.master io_link,
    output logic [OUT_W-1:0]      o_outstanding,
    output logic                  o_err_len,
    output logic                  o_err_timeout,
    input  logic                  i_err_clr
);

    // Elaboration-time parameter sanity checks.
    if (FLIT_W < 64) begin : g_chk_flit_w
        $error("FLIT_W must be at least 64");
    end
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_chk_max_len
        $error("MAX_LEN must be in 1..255");
    end
    if (MAX_OUT < 1) begin : g_chk_max_out
        $error("MAX_OUT must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    localparam logic [7:0]       MaxLen = 8'(MAX_LEN);
    localparam logic [OUT_W-1:0] MaxOut = OUT_W'(MAX_OUT);

    typedef enum logic [1:0] {TIdle, THead, TBody} tx_state_e;
    typedef enum logic       {RHead, RBody}        rx_state_e;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    tx_state_e         r_tx_state;
    tx_state_e         w_tx_state_d;
    logic [FLIT_W-1:0] r_tx_flit;
    logic              r_tx_valid;
    logic [7:0]        r_tx_len;
    logic [7:0]        r_body_cnt;
    logic [OUT_W-1:0]  r_outstanding;

    logic              w_cmd_ready;
    logic              w_pld_ready;
    logic              w_cmd_acc;
    logic              w_len_bad;
    logic              w_tx_acc;
    logic              w_head_acc;
    logic              w_pld_acc;
    logic              w_body_done;
    logic [FLIT_W-1:0] w_head;

    assign w_len_bad   = io_link.cmd_len > MaxLen;
    assign w_cmd_acc   = io_link.cmd_valid && w_cmd_ready;
    assign w_tx_acc    = r_tx_valid && io_link.tx_ready;
    assign w_head_acc  = w_tx_acc && (r_tx_state == THead);
    assign w_pld_acc   = io_link.pld_valid && w_pld_ready;
    // All payload flits for this packet have been taken from the host.
    assign w_body_done = (r_body_cnt == r_tx_len);

    always_comb begin
        w_head         = '0;
        w_head[63:60]  = io_link.cmd_dst_row;
        w_head[59:56]  = io_link.cmd_dst_col;
        w_head[55:48]  = io_link.cmd_len;
        w_head[47:40]  = io_link.cmd_tag;
        w_head[37:32]  = io_link.cmd_opcode;
        w_head[31:0]   = io_link.cmd_addr;
    end

    // TX FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TIdle;
        end else begin
            r_tx_state <= w_tx_state_d;
        end
    end

    // TX FSM: next state
    always_comb begin
        w_tx_state_d = r_tx_state;
        unique case (r_tx_state)
            TIdle: begin
                if (w_cmd_acc && !w_len_bad) begin
                    w_tx_state_d = THead;
                end
            end
            THead: begin
                if (w_tx_acc) begin
                    w_tx_state_d = (r_tx_len != 8'd0) ? TBody : TIdle;
                end
            end
            TBody: begin
                // Once the last payload flit is loaded, the only pending flit is that one.
                if (w_body_done && w_tx_acc) begin
                    w_tx_state_d = TIdle;
                end
            end
            default: w_tx_state_d = TIdle;
        endcase
    end

    // TX FSM: outputs
    always_comb begin
        w_cmd_ready = (r_tx_state == TIdle) && (r_outstanding < MaxOut);
        w_pld_ready = (r_tx_state == TBody) && !w_body_done &&
                      (!r_tx_valid || io_link.tx_ready);
    end

    // TX flit register: loads head or payload, drops valid once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_flit  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_len   <= 8'd0;
            r_body_cnt <= 8'd0;
        end else if (w_cmd_acc && !w_len_bad) begin
            r_tx_flit  <= w_head;
            r_tx_valid <= 1'b1;
            r_tx_len   <= io_link.cmd_len;
            r_body_cnt <= 8'd0;
        end else if (w_pld_acc) begin
            r_tx_flit  <= io_link.pld_data;
            r_tx_valid <= 1'b1;
            r_body_cnt <= r_body_cnt + 8'd1;
        end else if (w_tx_acc) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign io_link.cmd_ready = w_cmd_ready;
    assign io_link.pld_ready = w_pld_ready;
    assign io_link.tx_flit   = r_tx_flit;
    assign io_link.tx_valid  = r_tx_valid;

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    rx_state_e         r_rx_state;
    rx_state_e         w_rx_state_d;
    logic [7:0]        r_rx_cnt;
    logic              r_rsp_hdr_valid;
    logic [7:0]        r_rsp_tag;
    logic [7:0]        r_rsp_len;
    logic [5:0]        r_rsp_opcode;

    logic              w_rx_ready;
    logic              w_rx_acc;
    logic              w_rx_head_acc;
    logic              w_rx_body_acc;
    logic [FLIT_W-1:0] w_rsp_data;
    logic              w_rsp_data_valid;

    assign w_rx_acc      = io_link.rx_valid && w_rx_ready;
    assign w_rx_head_acc = w_rx_acc && (r_rx_state == RHead);
    assign w_rx_body_acc = w_rx_acc && (r_rx_state == RBody);

    // RX FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RHead;
        end else begin
            r_rx_state <= w_rx_state_d;
        end
    end

    // RX FSM: next state
    always_comb begin
        w_rx_state_d = r_rx_state;
        unique case (r_rx_state)
            RHead: begin
                if (w_rx_head_acc && (io_link.rx_flit[55:48] != 8'd0)) begin
                    w_rx_state_d = RBody;
                end
            end
            RBody: begin
                if (w_rx_body_acc && (r_rx_cnt == r_rsp_len - 8'd1)) begin
                    w_rx_state_d = RHead;
                end
            end
            default: w_rx_state_d = RHead;
        endcase
    end

    // RX FSM: outputs; payload is a zero-latency pass-through.
    always_comb begin
        w_rx_ready       = 1'b1;
        w_rsp_data       = '0;
        w_rsp_data_valid = 1'b0;
        if (r_rx_state == RBody) begin
            w_rx_ready       = io_link.rsp_data_ready;
            w_rsp_data       = io_link.rx_flit;
            w_rsp_data_valid = io_link.rx_valid;
        end
    end

    // Header latch and body counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_hdr_valid <= 1'b0;
            r_rsp_tag       <= 8'd0;
            r_rsp_len       <= 8'd0;
            r_rsp_opcode    <= 6'd0;
            r_rx_cnt        <= 8'd0;
        end else begin
            r_rsp_hdr_valid <= w_rx_head_acc;
            if (w_rx_head_acc) begin
                r_rsp_tag    <= io_link.rx_flit[47:40];
                r_rsp_len    <= io_link.rx_flit[55:48];
                r_rsp_opcode <= io_link.rx_flit[37:32];
                r_rx_cnt     <= 8'd0;
            end else if (w_rx_body_acc) begin
                r_rx_cnt     <= r_rx_cnt + 8'd1;
            end
        end
    end

    assign io_link.rx_ready       = w_rx_ready;
    assign io_link.rsp_hdr_valid  = r_rsp_hdr_valid;
    assign io_link.rsp_tag        = r_rsp_tag;
    assign io_link.rsp_len        = r_rsp_len;
    assign io_link.rsp_opcode     = r_rsp_opcode;
    assign io_link.rsp_data       = w_rsp_data;
    assign io_link.rsp_data_valid = w_rsp_data_valid;

    // ------------------------------------------------------------------------
    // Outstanding counter and sticky errors
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            unique case ({w_head_acc, w_rx_head_acc})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                // A stray response at zero must not wrap.
                2'b01:   r_outstanding <= (r_outstanding != '0) ?
                                          r_outstanding - OUT_W'(1) : '0;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    logic r_err_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_len <= 1'b0;
        end else if (w_cmd_acc && w_len_bad) begin
            r_err_len <= 1'b1;
        end else if (i_err_clr) begin
            r_err_len <= 1'b0;
        end
    end

    assign o_outstanding = r_outstanding;
    assign o_err_len     = r_err_len;

`ifdef HOST_LINK_TIMEOUT_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WdLimit = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WdLast  = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err_timeout;
    logic            w_wd_run;
    logic            w_wd_fire;

    assign w_wd_run  = (r_outstanding != '0) && !w_rx_head_acc;
    // Fire only on the step into the limit so err_clr sticks while the count holds.
    assign w_wd_fire = w_wd_run && (r_wd_cnt == WdLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (!w_wd_run) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != WdLimit) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timeout <= 1'b0;
        end else if (w_wd_fire) begin
            r_err_timeout <= 1'b1;
        end else if (i_err_clr) begin
            r_err_timeout <= 1'b0;
        end
    end

    assign o_err_timeout = r_err_timeout;
`else
    assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_neuraedge_host_link.sv
module tb_neuraedge_host_link;
    localparam int unsigned FLIT_W      = 64;
    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned MAX_OUT     = 8;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned OUT_W       = $clog2(MAX_OUT + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             err_clr;
    logic [OUT_W-1:0] outstanding;
    logic             err_len;
    logic             err_timeout;

    neuraedge_host_link_if #(.FLIT_W(FLIT_W)) link ();

    neuraedge_host_link #(
        .FLIT_W      (FLIT_W),
        .MAX_LEN     (MAX_LEN),
        .MAX_OUT     (MAX_OUT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_link       (link),
        .o_outstanding (outstanding),
        .o_err_len     (err_len),
        .o_err_timeout (err_timeout),
        .i_err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [7:0]  len;
        logic [7:0]  tag;
        logic [5:0]  op;
        logic [31:0] addr;
        int          tx_mode;   // 0: tx_ready=1, 1: toggling, 2: held 0
        logic [63:0] exp_head;
        logic        exp_err;
        int          exp_out;
    } cmd_vec_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          m_out = 0;
    int          hdr_pulses = 0;
    int          txr_mode = 0;
    int          rdr_mode = 0;
    logic [63:0] q_tx[$];
    logic [63:0] q_rsp[$];
    logic [7:0]  q_hdr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: got timeout/unexpected required handshake", name);
    endtask

    function automatic logic [63:0] head_of(input cmd_vec_t v);
        return {v.row, v.col, v.len, v.tag, 2'b00, v.op, v.addr};
    endfunction

    function automatic logic [63:0] pld_of(input logic [7:0] tag, input int i);
        return {16'hA5C3, tag, 8'h00, 32'(i)};
    endfunction

    function automatic logic [63:0] rx_head(input logic [7:0] len, input logic [7:0] tag,
                                            input logic [5:0] op);
        return {8'h00, len, tag, 2'b00, op, 32'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready drivers for the NPU input side and the response consumer.
    initial begin
        link.tx_ready       = 1'b1;
        link.rsp_data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (txr_mode)
                0:       link.tx_ready = 1'b1;
                1:       link.tx_ready = !link.tx_ready;
                default: link.tx_ready = 1'b0;
            endcase
            link.rsp_data_ready = (rdr_mode != 0) ? !link.rsp_data_ready : 1'b1;
        end
    end

    // Scoreboard monitor: sampled on the falling edge, transfers happen on the next rising edge.
    initial begin
        logic        stall_seen;
        logic [63:0] stall_flit;
        stall_seen = 1'b0;
        stall_flit = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_seen) begin
                    check("tx_hold_valid", link.tx_valid, 1'b1);
                    check("tx_hold_flit", link.tx_flit, stall_flit);
                end
                stall_seen = link.tx_valid && !link.tx_ready;
                stall_flit = link.tx_flit;
                if (link.tx_valid && link.tx_ready) begin
                    if (q_tx.size() == 0) fail("tx_unexpected_flit");
                    else check("tx_flit", link.tx_flit, q_tx.pop_front());
                end
                if (link.rsp_data_valid && link.rsp_data_ready) begin
                    if (q_rsp.size() == 0) fail("rsp_unexpected_data");
                    else check("rsp_data", link.rsp_data, q_rsp.pop_front());
                end
                if (link.rsp_hdr_valid) begin
                    hdr_pulses++;
                    if (q_hdr.size() == 0) fail("rsp_unexpected_hdr");
                    else check("rsp_tag", link.rsp_tag, q_hdr.pop_front());
                end
            end else begin
                stall_seen = 1'b0;
            end
        end
    end

    task automatic send_cmd(input cmd_vec_t v);
        int t;
        t = 0;
        link.cmd_valid   = 1'b1;
        link.cmd_dst_row = v.row;
        link.cmd_dst_col = v.col;
        link.cmd_len     = v.len;
        link.cmd_tag     = v.tag;
        link.cmd_opcode  = v.op;
        link.cmd_addr    = v.addr;
        @(negedge clk);
        while (!link.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!link.cmd_ready) fail("cmd_accept_timeout");
        tick();
        link.cmd_valid = 1'b0;
    endtask

    task automatic send_plds(input int first, input int count, input logic [7:0] tag);
        for (int i = first; i < first + count; i++) begin
            int t;
            t = 0;
            link.pld_valid = 1'b1;
            link.pld_data  = pld_of(tag, i);
            @(negedge clk);
            while (!link.pld_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!link.pld_ready) fail("pld_accept_timeout");
            check("cmd_ready_busy", link.cmd_ready, 1'b0);
            tick();
        end
        link.pld_valid = 1'b0;
    endtask

    task automatic wait_tx_drain();
        int t;
        t = 0;
        @(negedge clk);
        while (q_tx.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q_tx.size() != 0) fail("tx_drain_timeout");
        tick();
    endtask

    task automatic send_rx(input logic [63:0] flit);
        int t;
        t = 0;
        link.rx_valid = 1'b1;
        link.rx_flit  = flit;
        @(negedge clk);
        while (!link.rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!link.rx_ready) fail("rx_accept_timeout");
        tick();
        link.rx_valid = 1'b0;
    endtask

    task automatic rx_head_only(input logic [7:0] tag);
        q_hdr.push_back(tag);
        send_rx(rx_head(8'd0, tag, 6'd0));
        if (m_out > 0) m_out--;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        cmd_vec_t vecs[5];
        cmd_vec_t c;
        int       p0;

        vecs[0] = '{4'h1, 4'h0, 8'd0,  8'h5A, 6'h00, 32'h0000_1000, 0,
                    64'h1000_5A00_0000_1000, 1'b0, 1};
        vecs[1] = '{4'h2, 4'h3, 8'd3,  8'h22, 6'h15, 32'hDEAD_BEEF, 1,
                    64'h2303_2215_DEAD_BEEF, 1'b0, 2};
        vecs[2] = '{4'h4, 4'h5, 8'd20, 8'h33, 6'h01, 32'h0000_0000, 0,
                    64'h0, 1'b1, 2};
        vecs[3] = '{4'hF, 4'hF, 8'd16, 8'h44, 6'h3F, 32'hFFFF_FFFF, 1,
                    64'hFF10_443F_FFFF_FFFF, 1'b0, 3};
        vecs[4] = '{4'h0, 4'h1, 8'd1,  8'h55, 6'h02, 32'h0000_0080, 0,
                    64'h0101_5502_0000_0080, 1'b0, 4};

        rst_n            = 1'b0;
        err_clr          = 1'b0;
        link.cmd_valid   = 1'b0;
        link.cmd_dst_row = '0;
        link.cmd_dst_col = '0;
        link.cmd_len     = '0;
        link.cmd_tag     = '0;
        link.cmd_opcode  = '0;
        link.cmd_addr    = '0;
        link.pld_valid   = 1'b0;
        link.pld_data    = '0;
        link.rx_valid    = 1'b0;
        link.rx_flit     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", link.cmd_ready, 1'b1);
        check("rst_tx_valid", link.tx_valid, 1'b0);
        check("rst_tx_flit", link.tx_flit, 64'h0);
        check("rst_pld_ready", link.pld_ready, 1'b0);
        check("rst_hdr_valid", link.rsp_hdr_valid, 1'b0);
        check("rst_rsp_valid", link.rsp_data_valid, 1'b0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err_len", err_len, 1'b0);
        check("rst_err_timeout", err_timeout, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Command table: head format, payload order, stalls, length boundary and overflow
        foreach (vecs[k]) begin
            txr_mode = vecs[k].tx_mode;
            if (!vecs[k].exp_err) begin
                q_tx.push_back(vecs[k].exp_head);
                for (int i = 0; i < int'(vecs[k].len); i++) q_tx.push_back(pld_of(vecs[k].tag, i));
            end
            send_cmd(vecs[k]);
            if (!vecs[k].exp_err) begin
                send_plds(0, int'(vecs[k].len), vecs[k].tag);
                m_out++;
            end
            wait_tx_drain();
            @(negedge clk);
            check("vec_cmd_ready_idle", link.cmd_ready, 1'b1);
            check("vec_outstanding", outstanding, vecs[k].exp_out);
            check("vec_err_len", err_len, vecs[k].exp_err);
            if (vecs[k].exp_err) begin
                check("err_tx_valid", link.tx_valid, 1'b0);
                tick();
                check("err_len_sticky", err_len, 1'b1);
                pulse_err_clr();
                @(negedge clk);
                check("err_len_cleared", err_len, 1'b0);
            end
            tick();
        end
        txr_mode = 0;

        // New error in the same cycle as err_clr: error wins
        c = vecs[2];
        err_clr = 1'b1;
        send_cmd(c);
        err_clr = 1'b0;
        @(negedge clk);
        check("err_vs_clr", err_len, 1'b1);
        tick();
        pulse_err_clr();
        @(negedge clk);
        check("err_clr_after", err_len, 1'b0);
        tick();

        // Response with two payload flits, consumer stalling every other cycle
        rdr_mode = 1;
        p0 = hdr_pulses;
        q_hdr.push_back(8'h11);
        q_rsp.push_back(64'hCAFE_0000_0000_0000);
        q_rsp.push_back(64'hCAFE_0000_0000_0001);
        send_rx(rx_head(8'd2, 8'h11, 6'h05));
        send_rx(64'hCAFE_0000_0000_0000);
        send_rx(64'hCAFE_0000_0000_0001);
        m_out--;
        @(negedge clk);
        check("rsp_hdr_pulses", hdr_pulses - p0, 1);
        check("rsp_tag_held", link.rsp_tag, 8'h11);
        check("rsp_len_held", link.rsp_len, 8'd2);
        check("rsp_opcode_held", link.rsp_opcode, 6'h05);
        check("rsp_outstanding", outstanding, m_out);
        check("rx_back_to_head", link.rx_ready, 1'b1);
        rdr_mode = 0;
        tick();

        // Drain, then a stray response must not underflow
        while (m_out > 0) rx_head_only(8'h60);
        rx_head_only(8'h61);
        @(negedge clk);
        check("no_underflow", outstanding, 0);
        tick();

        // Fill to MAX_OUT
        for (int i = 0; i < int'(MAX_OUT); i++) begin
            c = '{4'h3, 4'h3, 8'd0, 8'(8'h80 + i), 6'h01, 32'(i), 0, 64'h0, 1'b0, 0};
            q_tx.push_back(head_of(c));
            send_cmd(c);
            m_out++;
        end
        wait_tx_drain();
        @(negedge clk);
        check("full_outstanding", outstanding, MAX_OUT);
        check("full_cmd_ready", link.cmd_ready, 1'b0);
        tick();
        rx_head_only(8'h70);
        @(negedge clk);
        check("full_minus_one", outstanding, MAX_OUT - 1);
        // Park a head flit, then accept it in the same cycle as a response head
        txr_mode = 2;
        repeat (2) tick();
        c = '{4'h3, 4'h3, 8'd0, 8'h90, 6'h01, 32'h0, 0, 64'h0, 1'b0, 0};
        q_tx.push_back(head_of(c));
        send_cmd(c);
        @(negedge clk);
        check("parked_tx_valid", link.tx_valid, 1'b1);
        check("parked_outstanding", outstanding, MAX_OUT - 1);
        txr_mode = 0;
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!link.tx_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!link.tx_ready) fail("tx_ready_timeout");
        end
        #1;
        q_hdr.push_back(8'h71);
        link.rx_valid = 1'b1;
        link.rx_flit  = rx_head(8'd0, 8'h71, 6'd0);
        tick();
        link.rx_valid = 1'b0;
        @(negedge clk);
        check("same_cycle_outstanding", outstanding, MAX_OUT - 1);
        check("same_cycle_tx_idle", link.tx_valid, 1'b0);
        tick();
        c = '{4'h3, 4'h3, 8'd0, 8'h91, 6'h01, 32'h0, 0, 64'h0, 1'b0, 0};
        q_tx.push_back(head_of(c));
        send_cmd(c);
        wait_tx_drain();
        @(negedge clk);
        check("refill_outstanding", outstanding, MAX_OUT);
        check("refill_cmd_ready", link.cmd_ready, 1'b0);
        tick();
        m_out = MAX_OUT;
        while (m_out > 0) rx_head_only(8'h72);

        // Reset in the middle of a TX body
        c = '{4'h6, 4'h7, 8'd3, 8'hB0, 6'h0A, 32'h1234_5678, 0, 64'h0, 1'b0, 0};
        q_tx.push_back(head_of(c));
        q_tx.push_back(pld_of(8'hB0, 0));
        q_tx.push_back(pld_of(8'hB0, 1));
        send_cmd(c);
        send_plds(0, 1, 8'hB0);
        begin
            int t;
            t = 0;
            while (q_tx.size() > 1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (q_tx.size() > 1) fail("body_drain_timeout");
        end
        tick();
        txr_mode = 2;
        repeat (2) tick();
        send_plds(1, 1, 8'hB0);
        @(negedge clk);
        check("midbody_tx_valid", link.tx_valid, 1'b1);
        check("midbody_outstanding", outstanding, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", link.tx_valid, 1'b0);
        check("rst_mid_cmd_ready", link.cmd_ready, 1'b1);
        check("rst_mid_outstanding", outstanding, 0);
        check("rst_mid_pld_ready", link.pld_ready, 1'b0);
        q_tx.delete();
        m_out = 0;
        txr_mode = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Watchdog: one command with no response
        c = '{4'h1, 4'h1, 8'd0, 8'hC0, 6'h03, 32'h0, 0, 64'h0, 1'b0, 0};
        q_tx.push_back(head_of(c));
        send_cmd(c);
        m_out = 1;
        repeat (8) tick();
        @(negedge clk);
        check("wd_early", err_timeout, 1'b0);
        repeat (14) tick();
        @(negedge clk);
`ifdef HOST_LINK_TIMEOUT_EN
        check("wd_expired", err_timeout, 1'b1);
`else
        check("wd_tied_off", err_timeout, 1'b0);
`endif
        tick();
        pulse_err_clr();
        repeat (3) tick();
        @(negedge clk);
        check("wd_cleared", err_timeout, 1'b0);
        tick();
        rx_head_only(8'hC0);
        @(negedge clk);
        check("wd_final_outstanding", outstanding, 0);

        repeat (3) tick();
        check("q_tx_empty", q_tx.size(), 0);
        check("q_rsp_empty", q_rsp.size(), 0);
        check("q_hdr_empty", q_hdr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
